// File: rtl/cache_pkg.sv
// Cache-side types shared by the caches and the memory arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DGNT = 2'd1,
        ARB_IGNT = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_CTR_W = 3;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word and RAM handshake status.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of dcache completions since the last icache completion; flags icache starvation.
module arb_starve_ctr
    import cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_done_i,
    input  logic i_done_i,
    output logic starved_o
);

    logic [STARVE_CTR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_done_i) begin
            count_d = '0;
        end else if (d_done_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign starved_o = (32'(count_q) >= STARVE_LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between icache and dcache, dcache first.
// Define ARB_FAIR_EN to let a starved icache win after STARVE_LIMIT dcache completions.
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      iwait,
    output word_t     iload,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      ram_err
);

    arb_state_t state;
    logic       d_req;
    logic       d_done;
    logic       i_done;
    logic       starved;

    assign d_req  = dREN | dWEN;
    assign d_done = (state == ARB_DGNT) && (ramstate == ACCESS);
    assign i_done = (state == ARB_IGNT) && (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .d_done_i (d_done),
        .i_done_i (i_done),
        .starved_o(starved)
    );
`else
    // Strict priority: the limit is kept only so both builds share one parameter list.
    assign starved = 1'b0 & (STARVE_LIMIT == 0);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ARB_IDLE;
            ram_err <= 1'b0;
        end else begin
            if (ramstate == ERROR) begin
                ram_err <= 1'b1;
            end
            case (state)
                ARB_IDLE: begin
                    if (starved && iREN) begin
                        state <= ARB_IGNT;
                    end else if (d_req) begin
                        state <= ARB_DGNT;
                    end else if (iREN) begin
                        state <= ARB_IGNT;
                    end
                end
                // A dropped request abandons the grant; ERROR holds like BUSY.
                ARB_DGNT: if ((ramstate == ACCESS) || !d_req) state <= ARB_IDLE;
                ARB_IGNT: if ((ramstate == ACCESS) || !iREN)  state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            ARB_DGNT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
            end
            ARB_IGNT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dwait = ~d_done;
    assign iwait = ~i_done;
    assign dload = ramload;
    assign iload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter, plus async-reset and starvation sequences.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;
    import cache_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      iwait;
    word_t     iload;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ram_err;

    cache_mem_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .ramstate(ramstate),
        .ramload (ramload),
        .iwait   (iwait),
        .iload   (iload),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ram_err (ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic      iren;
        word_t     iaddr;
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        ramstate_t rs;
        word_t     rload;
        logic      e_iwait;
        logic      e_dwait;
        logic      e_ren;
        logic      e_wen;
        word_t     e_addr;
        logic      chk_store;
        logic      chk_load;
        logic      e_err;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic ir, input word_t ia, input logic dr, input logic dw,
                       input word_t da, input word_t ds, input ramstate_t rs, input word_t rl,
                       input logic ei, input logic ed, input logic er, input logic ew,
                       input word_t ea, input logic cs, input logic cl, input logic ee);
        vec_t v;
        v = '{ir, ia, dr, dw, da, ds, rs, rl, ei, ed, er, ew, ea, cs, cl, ee};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iREN     = v.iren;
        iaddr    = v.iaddr;
        dREN     = v.dren;
        dWEN     = v.dwen;
        daddr    = v.daddr;
        dstore   = v.dstore;
        ramstate = v.rs;
        ramload  = v.rload;
    endtask

    int    d_done;
    int    i_done;
    word_t first_i_at;
    word_t first_i_addr;

    initial begin
        nRST = 1'b0;
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramstate = FREE; ramload = 0;

        //   iren iaddr  dren dwen daddr  dstore  rs ramload  iw dw ren wen addr cst cld err
        add(0, 0,     0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, BUSY,   0,           1, 1, 1, 0, 'h40,  0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, BUSY,   0,           1, 1, 1, 0, 'h40,  0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, ACCESS, 'h8C220004,  0, 1, 1, 0, 'h40,  0, 1, 0);
        add(0, 0,     0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(1, 'h40,  1, 0, 'h100, 0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(1, 'h40,  1, 0, 'h100, 0, BUSY,   0,           1, 1, 1, 0, 'h100, 0, 0, 0);
        add(1, 'h40,  1, 0, 'h100, 0, ACCESS, 'h11112222,  1, 0, 1, 0, 'h100, 0, 1, 0);
        add(1, 'h40,  0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, BUSY,   0,           1, 1, 1, 0, 'h40,  0, 0, 0);
        add(1, 'h40,  0, 0, 0,     0, ACCESS, 'h33334444,  0, 1, 1, 0, 'h40,  0, 1, 0);
        add(0, 0,     0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0, 1, 1, 'h200, 'hDEADBEEF, FREE,   0,      1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0, 1, 1, 'h200, 'hDEADBEEF, BUSY,   0,      1, 1, 0, 1, 'h200, 1, 0, 0);
        add(0, 0, 1, 1, 'h200, 'hDEADBEEF, ACCESS, 0,      1, 0, 0, 1, 'h200, 1, 0, 0);
        add(0, 0,     0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0,     1, 0, 'h300, 0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0,     1, 0, 'h300, 0, BUSY,   0,           1, 1, 1, 0, 'h300, 0, 0, 0);
        add(0, 0,     0, 0, 'h300, 0, BUSY,   0,           1, 1, 0, 0, 'h300, 0, 0, 0);
        add(0, 0,     0, 0, 'h300, 0, BUSY,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0,     1, 0, 'h400, 0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0,     1, 0, 'h400, 0, ERROR,  0,           1, 1, 1, 0, 'h400, 0, 0, 0);
        add(0, 0,     1, 0, 'h400, 0, ERROR,  0,           1, 1, 1, 0, 'h400, 0, 0, 1);
        add(0, 0,     1, 0, 'h400, 0, ACCESS, 'h55556666,  1, 0, 1, 0, 'h400, 0, 1, 1);
        add(0, 0,     0, 0, 0,     0, FREE,   0,           1, 1, 0, 0, 0,     0, 0, 1);

        // Reset state
        #12;
        chk("rst_iwait", 0, 32'(iwait), 1);
        chk("rst_dwait", 0, 32'(dwait), 1);
        chk("rst_ren", 0, 32'(ramREN), 0);
        chk("rst_wen", 0, 32'(ramWEN), 0);
        chk("rst_err", 0, 32'(ram_err), 0);
        nRST = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge CLK);
            #1 drive(vq[i]);
            #2;
            chk("iwait", i, 32'(iwait), 32'(vq[i].e_iwait));
            chk("dwait", i, 32'(dwait), 32'(vq[i].e_dwait));
            chk("ramREN", i, 32'(ramREN), 32'(vq[i].e_ren));
            chk("ramWEN", i, 32'(ramWEN), 32'(vq[i].e_wen));
            chk("ramaddr", i, ramaddr, vq[i].e_addr);
            chk("ram_err", i, 32'(ram_err), 32'(vq[i].e_err));
            if (vq[i].chk_store) chk("ramstore", i, ramstore, vq[i].dstore);
            if (vq[i].chk_load) begin
                chk("iload", i, iload, vq[i].rload);
                chk("dload", i, dload, vq[i].rload);
            end
        end

        // Asynchronous reset in the middle of a dcache grant
        @(posedge CLK);
        #1 dREN = 1; daddr = 'h500; ramstate = BUSY;
        @(posedge CLK);
        #2 chk("agrant_ren", 0, 32'(ramREN), 1);
        #1 nRST = 1'b0;
        #1;
        chk("arst_ren", 0, 32'(ramREN), 0);
        chk("arst_addr", 0, ramaddr, 0);
        chk("arst_dwait", 0, 32'(dwait), 1);
        chk("arst_err", 0, 32'(ram_err), 0);
        dREN = 0; daddr = 0; ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;

        // Continuous contention: icache only gets in through the starvation guard
        d_done = 0;
        i_done = 0;
        first_i_at = 32'hFFFF_FFFF;
        first_i_addr = 0;
        @(posedge CLK);
        #1 iREN = 1; iaddr = 'h40; dREN = 1; daddr = 'h100; ramstate = ACCESS;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (!dwait) d_done++;
            if (!iwait) begin
                if (i_done == 0) begin
                    first_i_at = 32'(d_done);
                    first_i_addr = ramaddr;
                end
                i_done++;
            end
            @(posedge CLK);
            #1;
        end
`ifdef ARB_FAIR_EN
        chk("fair_first_i_after_d", 0, first_i_at, 4);
        chk("fair_i_addr", 0, first_i_addr, 'h40);
        chk("fair_i_granted", 0, 32'(i_done > 0), 1);
`else
        chk("strict_i_done", 0, 32'(i_done), 0);
        chk("strict_d_done", 0, 32'(d_done), 20);
`endif
        iREN = 0; dREN = 0; ramstate = FREE;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
